// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU control path.
//   - Instruction field widths and bit positions: opcode [3:0], reg_sel [5:4], imm [15:6].
//   - opcode_e    : defined opcodes. Values 6 and 10-14 are undefined and are treated as illegal.
//   - seq_state_e : instruction sequencer FSM states.
package cpu_pkg;

  localparam int OPC_W   = 4;
  localparam int SEL_W   = 2;
  localparam int IMM_W   = 10;
  localparam int OPC_LSB = 0;
  localparam int SEL_LSB = 4;
  localparam int IMM_LSB = 6;

  typedef enum logic [OPC_W-1:0] {
    ADD      = 4'd0,
    SUBTRACT = 4'd1,
    AND_OP   = 4'd2,
    OR_OP    = 4'd3,
    XOR_OP   = 4'd4,
    NOT_OP   = 4'd5,
    LOAD     = 4'd7,
    STOREMEM = 4'd8,
    STORERF  = 4'd9,
    NOP      = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_EXEC,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   ir          in  INSTRUCTION_WIDTH  instruction register contents
//   opcode      out OPC_W              ir[3:0]
//   reg_sel     out SEL_W              ir[5:4]
//   imm         out IMM_W              ir[15:6]
//   is_alu      out 1                  opcode is ADD..NOT_OP
//   is_load     out 1                  opcode is LOAD
//   is_storerf  out 1                  opcode is STORERF
//   is_storemem out 1                  opcode is STOREMEM
//   illegal     out 1                  opcode is undefined (6, 10-14)
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic [INSTRUCTION_WIDTH-1:0] ir,
  output logic [OPC_W-1:0]             opcode,
  output logic [SEL_W-1:0]             reg_sel,
  output logic [IMM_W-1:0]             imm,
  output logic                         is_alu,
  output logic                         is_load,
  output logic                         is_storerf,
  output logic                         is_storemem,
  output logic                         illegal
);

  assign opcode  = ir[OPC_LSB +: OPC_W];
  assign reg_sel = ir[SEL_LSB +: SEL_W];
  assign imm     = ir[IMM_LSB +: IMM_W];

  always_comb begin
    is_alu      = 1'b0;
    is_load     = 1'b0;
    is_storerf  = 1'b0;
    is_storemem = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      ADD, SUBTRACT, AND_OP, OR_OP, XOR_OP, NOT_OP: is_alu = 1'b1;
      LOAD:     is_load     = 1'b1;
      STORERF:  is_storerf  = 1'b1;
      STOREMEM: is_storemem = 1'b1;
      NOP:      ;
      default:  illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer for the 16-bit accumulator CPU.
// Steps a PC through program memory, latches each word into the IR, and
// decodes it into one-cycle control strobes (mem_req is held until mem_ack).
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                begin program at address 0 (only honoured in IDLE)
//   halt                 stop at the next instruction boundary
//   instruction_address  PC to program memory
//   instruction          word from program memory (combinational read)
//   alu_en, alu_op       ALU strobe and opcode (alu_op is 0 when alu_en is 0)
//   rf_we                STORERF strobe
//   load_en              LOAD strobe
//   reg_sel, imm         IR fields, valid in every state
//   mem_req, mem_ack     STOREMEM handshake
//   busy                 high in any state other than IDLE
//   done                 one-cycle pulse at the end of a program or after halt
//   illegal_op           sticky undefined-opcode flag, cleared by start
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             halt,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
  input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic                             alu_en,
  output logic [OPC_W-1:0]                 alu_op,
  output logic                             rf_we,
  output logic                             load_en,
  output logic [SEL_W-1:0]                 reg_sel,
  output logic [IMM_W-1:0]                 imm,
  output logic                             mem_req,
  input  logic                             mem_ack,
  output logic                             busy,
  output logic                             done,
  output logic                             illegal_op
);

  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC =
    BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);
  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] PC_ONE = BITS_FOR_INSTRUCTIONS'(1);
  // Reset IR to a NOP so reg_sel/imm read as zero out of reset.
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_IR =
    {{(INSTRUCTION_WIDTH-OPC_W){1'b0}}, NOP};

  seq_state_e                       state_reg, state_next;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc_reg, pc_next;
  logic [INSTRUCTION_WIDTH-1:0]     ir_reg, ir_next;
  logic                             illegal_reg, illegal_next;

  logic [OPC_W-1:0] dec_opcode;
  logic             dec_is_alu, dec_is_load, dec_is_storerf, dec_is_storemem, dec_illegal;

  instr_decoder #(
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)
  ) u_decoder (
    .ir          (ir_reg),
    .opcode      (dec_opcode),
    .reg_sel     (reg_sel),
    .imm         (imm),
    .is_alu      (dec_is_alu),
    .is_load     (dec_is_load),
    .is_storerf  (dec_is_storerf),
    .is_storemem (dec_is_storemem),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SEQ_IDLE;
      pc_reg      <= '0;
      ir_reg      <= NOP_IR;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    illegal_next = illegal_reg;
    alu_en       = 1'b0;
    alu_op       = '0;
    rf_we        = 1'b0;
    load_en      = 1'b0;
    mem_req      = 1'b0;
    done         = 1'b0;
    busy         = (state_reg != SEQ_IDLE);

    case (state_reg)
      SEQ_IDLE: begin
        if (start) begin
          pc_next      = '0;
          illegal_next = 1'b0;
          state_next   = SEQ_FETCH;
        end
      end
      SEQ_FETCH: begin
        ir_next    = instruction;
        state_next = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        alu_en  = dec_is_alu;
        alu_op  = dec_is_alu ? dec_opcode : '0;
        rf_we   = dec_is_storerf;
        load_en = dec_is_load;
        mem_req = dec_is_storemem;
        if (dec_illegal) illegal_next = 1'b1;
        // STOREMEM parks here until acked; halt is only looked at on the
        // cycle the instruction actually retires.
        if (!dec_is_storemem || mem_ack) begin
          if (pc_reg == LAST_PC || halt) begin
            state_next = SEQ_DONE;
          end else begin
            pc_next    = pc_reg + PC_ONE;
            state_next = SEQ_FETCH;
          end
        end
      end
      SEQ_DONE: begin
        done       = 1'b1;
        state_next = SEQ_IDLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  assign instruction_address = pc_reg;
  assign illegal_op          = illegal_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer. For each directed program it
// builds the expected cycle-by-cycle output trace from the instruction list,
// then runs the DUT and compares every cycle, plus literal spot checks.
module tb_instruction_sequencer;

  typedef struct packed {
    logic [4:0] addr;
    logic       alu_en;
    logic [3:0] alu_op;
    logic       rf_we;
    logic       load_en;
    logic       mem_req;
    logic [1:0] reg_sel;
    logic [9:0] imm;
    logic       busy;
    logic       done;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic drv_ack;
    logic drv_halt;
  } exp_t;

  logic        clk, rst_n, start, halt, mem_ack;
  logic [4:0]  instruction_address;
  logic [15:0] instruction;
  logic        alu_en, rf_we, load_en, mem_req, busy, done, illegal_op;
  logic [3:0]  alu_op;
  logic [1:0]  reg_sel;
  logic [9:0]  imm;

  logic [15:0] prog_mem [32];
  int          wait_cfg [32];
  logic [15:0] last_ir;
  int          n_checks, n_fail;
  int          busy_cnt, done_cnt, alu_cnt, load_cnt, rf_cnt, mreq_cnt;
  logic [9:0]  load_imm_seen;

  localparam logic [15:0] W_NOP      = 16'h000F;
  localparam logic [15:0] W_STORERF2 = 16'h0029;  // STORERF sel=2
  localparam logic [15:0] W_LOAD     = 16'hFF27;  // LOAD imm=0x3FC sel=2
  localparam logic [15:0] W_SMEM123  = 16'h1EC8;  // STOREMEM imm=123 sel=0
  localparam logic [15:0] W_ILL      = 16'h000A;

  assign instruction = prog_mem[instruction_address];

  instruction_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .halt                (halt),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .alu_en              (alu_en),
    .alu_op              (alu_op),
    .rf_we               (rf_we),
    .load_en             (load_en),
    .reg_sel             (reg_sel),
    .imm                 (imm),
    .mem_req             (mem_req),
    .mem_ack             (mem_ack),
    .busy                (busy),
    .done                (done),
    .illegal_op          (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    return {instruction_address, alu_en, alu_op, rf_we, load_en, mem_req,
            reg_sel, imm, busy, done, illegal_op};
  endfunction

  // Expected outputs while executing word w.
  function automatic obs_t exec_obs(logic [15:0] w, int pc, logic ill);
    obs_t o = '0;
    logic [3:0] op = w[3:0];
    o.addr    = pc[4:0];
    o.reg_sel = w[5:4];
    o.imm     = w[15:6];
    o.busy    = 1'b1;
    o.illegal = ill;
    if (op <= 4'd5) begin
      o.alu_en = 1'b1;
      o.alu_op = op;
    end else if (op == 4'd7) o.load_en = 1'b1;
    else if (op == 4'd8) o.mem_req = 1'b1;
    else if (op == 4'd9) o.rf_we = 1'b1;
    return o;
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) begin
      prog_mem[i] = W_NOP;
      wait_cfg[i] = 0;
    end
  endtask

  // Runs the program in prog_mem. halt_idx: address whose execution sees halt=1
  // (-1 none). abort_idx: trace index after which rst_n is dropped (-1 none).
  task automatic run(string name, int halt_idx, bit start_halt, int abort_idx, bit poke_start);
    exp_t        q[$];
    exp_t        e;
    int          pc = 0;
    logic        ill = 1'b0;
    logic [15:0] ir = last_ir;
    int          n_exec;
    bit          fin = 0;
    obs_t        got;

    while (!fin) begin
      e = '0;
      e.o.addr = pc[4:0]; e.o.reg_sel = ir[5:4]; e.o.imm = ir[15:6];
      e.o.busy = 1'b1; e.o.illegal = ill; e.drv_halt = (pc == halt_idx);
      q.push_back(e);
      ir = prog_mem[pc];
      n_exec = (ir[3:0] == 4'd8) ? wait_cfg[pc] + 1 : 1;
      for (int k = 0; k < n_exec; k++) begin
        e = '0;
        e.o = exec_obs(ir, pc, ill);
        e.drv_ack  = (ir[3:0] == 4'd8) && (k == n_exec - 1);
        e.drv_halt = (pc == halt_idx);
        q.push_back(e);
      end
      if (ir[3:0] == 4'd6 || (ir[3:0] >= 4'd10 && ir[3:0] <= 4'd14)) ill = 1'b1;
      if (pc == 31 || pc == halt_idx) fin = 1;
      else pc++;
    end
    e = '0;
    e.o.addr = pc[4:0]; e.o.reg_sel = ir[5:4]; e.o.imm = ir[15:6];
    e.o.busy = 1'b1; e.o.done = 1'b1; e.o.illegal = ill;
    q.push_back(e);
    e.o.busy = 1'b0; e.o.done = 1'b0;
    q.push_back(e);
    last_ir = ir;

    busy_cnt = 0; done_cnt = 0; alu_cnt = 0; load_cnt = 0; rf_cnt = 0; mreq_cnt = 0;
    load_imm_seen = '0;
    start = 1'b1;
    halt  = start_halt;
    @(negedge clk);
    start = 1'b0;
    foreach (q[i]) begin
      got = dut_obs();
      check($sformatf("%s[%0d]", name, i), got, q[i].o);
      $display("%s cyc %0d addr=%0d busy=%b done=%b alu=%b/%0d rf=%b ld=%b mreq=%b sel=%0d imm=%h ill=%b",
               name, i, got.addr, got.busy, got.done, got.alu_en, got.alu_op, got.rf_we,
               got.load_en, got.mem_req, got.reg_sel, got.imm, got.illegal);
      busy_cnt += int'(got.busy);
      done_cnt += int'(got.done);
      alu_cnt  += int'(got.alu_en);
      rf_cnt   += int'(got.rf_we);
      mreq_cnt += int'(got.mem_req);
      if (got.load_en) begin
        load_cnt++;
        load_imm_seen = got.imm;
      end
      mem_ack = q[i].drv_ack;
      halt    = q[i].drv_halt;
      start   = poke_start && q[i].o.busy;
      if (i == abort_idx) begin
        #1 rst_n = 1'b0;
        #1 check({name, "_async_rst"}, dut_obs(), '0);
        mem_ack = 1'b0; halt = 1'b0; start = 1'b0;
        @(negedge clk);
        check({name, "_rst_hold"}, dut_obs(), '0);
        rst_n   = 1'b1;
        last_ir = W_NOP;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0; halt = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; mem_ack = 1'b0;
    last_ir = W_NOP;
    clear_prog();
    #1 check("reset_state", dut_obs(), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", dut_obs(), '0);

    // 1: all NOPs, runs to the last address.
    run("nop32", -1, 0, -1, 0);
    check_int("nop32_busy_cycles", busy_cnt, 65);
    check_int("nop32_done_pulses", done_cnt, 1);
    check_int("nop32_alu_pulses", alu_cnt, 0);
    check_int("nop32_final_pc", int'(instruction_address), 31);
    check_int("nop32_illegal", int'(illegal_op), 0);

    // 2: ADD at 1..9, STORERF sel=2 at 10; start held high while busy.
    clear_prog();
    for (int i = 1; i <= 9; i++) prog_mem[i] = 16'((i * 3) << 6) | 16'h0010;
    prog_mem[10] = W_STORERF2;
    run("add_rf", 10, 0, -1, 1);
    check_int("add_rf_alu_pulses", alu_cnt, 9);
    check_int("add_rf_rf_pulses", rf_cnt, 1);
    check_int("add_rf_final_pc", int'(instruction_address), 10);

    // 3: LOAD imm=0x3FC sel=2.
    clear_prog();
    prog_mem[0] = W_LOAD;
    run("load", 0, 0, -1, 0);
    check_int("load_pulses", load_cnt, 1);
    check_int("load_imm", int'(load_imm_seen), 10'h3FC);

    // 4: STOREMEM imm=123 with 3 wait cycles, then with immediate ack.
    clear_prog();
    prog_mem[0] = W_SMEM123; wait_cfg[0] = 3;
    prog_mem[1] = W_SMEM123; wait_cfg[1] = 0;
    run("smem", 1, 0, -1, 0);
    check_int("smem_req_cycles", mreq_cnt, 5);

    // 5: undefined opcode at 5; sticky to done, cleared by next start.
    clear_prog();
    prog_mem[5] = W_ILL;
    run("illegal", 7, 0, -1, 0);
    check_int("illegal_sticky", int'(illegal_op), 1);
    clear_prog();
    run("illegal_clr", 2, 0, -1, 0);
    check_int("illegal_cleared", int'(illegal_op), 0);

    // 6: halt during a STOREMEM wait, then reset mid-wait, then restart.
    clear_prog();
    prog_mem[0] = W_SMEM123; wait_cfg[0] = 4;
    prog_mem[1] = W_LOAD;
    run("halt_wait", 0, 0, -1, 0);
    check_int("halt_wait_done", done_cnt, 1);
    check_int("halt_wait_pc", int'(instruction_address), 0);
    wait_cfg[0] = 10;
    run("abort", -1, 0, 3, 0);
    clear_prog();
    prog_mem[0] = W_LOAD;
    run("restart_start_halt", 0, 1, -1, 0);
    check_int("restart_load_pulses", load_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
